spm_mult_n: RTL and testbench

SPM_MULT_N -- requirements
Module: spm_mult_n

---
 rtl/spm_mult_n_if.sv | 28 ++
 rtl/spm_mult_n.sv | 122 ++++++++++++
 tb/tb_spm_mult_n.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spm_mult_n_if.sv
// Purpose     : request/result bundle for the bit-serial multiplier (operands in, product/status out).
// Latency     : none, wires only.
// Backpressure: none; the requester must only pulse start while busy is low.
// Ports       : start, signed_mode, mc, mp (requester -> multiplier);
//               prod, busy, done (multiplier -> requester).
interface spm_mult_n_if #(
    parameter int N = 8
);
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   mc;
    logic [N-1:0]   mp;
    logic [2*N-1:0] prod;
    logic           busy;
    logic           done;

    // Requester side: drives operands, observes the result.
    modport master (
        output start, signed_mode, mc, mp,
        input  prod, busy, done
    );

    // Multiplier side.
    modport slave (
        input  start, signed_mode, mc, mp,
        output prod, busy, done
    );
endinterface

// File: rtl/spm_mult_n.sv
// Purpose     : serial-parallel multiplier (signed or unsigned, N-bit operands, 2N-bit product),
//               one multiplier bit consumed and one product bit produced per clock, LSB first.
// Latency     : fixed 2N clocks from the start-sampling edge to done, independent of operands.
// Backpressure: none; start is ignored while busy, and the result holds in DONE until the next start.
// Ports       : clk, rst (async, active-high); bus = spm_mult_n_if.slave
//               (start/signed_mode/mc/mp in, prod/busy/done out).
module spm_mult_n #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    spm_mult_n_if.slave  bus
);

    localparam int CW = $clog2(2 * N) + 1;
    // Two guard bits above N keep the running partial sum free of overflow in both modes.
    localparam int AW = N + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q,   state_d;
    logic [N-1:0]   mc_q,      mc_d;
    logic [N-1:0]   mp_sr_q,   mp_sr_d;
    logic           mp_sign_q, mp_sign_d;
    logic           signed_q,  signed_d;
    logic [2*N-1:0] prod_q,    prod_d;
    logic [AW-1:0]  acc_q,     acc_d;
    logic [CW-1:0]  cnt_q,     cnt_d;
    logic           busy_q,    busy_d;
    logic           done_q,    done_d;

    logic [AW-1:0]  mc_ext;
    logic [AW-1:0]  addend;
    logic [AW-1:0]  sum;
    logic           mp_fill;

    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        mp_sr_d   = mp_sr_q;
        mp_sign_d = mp_sign_q;
        signed_d  = signed_q;
        prod_d    = prod_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;

        // Multiplicand widened per mode; the accumulator is two's complement throughout.
        mc_ext  = signed_q ? {{2{mc_q[N-1]}}, mc_q} : {2'b00, mc_q};
        addend  = mp_sr_q[0] ? mc_ext : '0;
        // acc_q is the high part of the partial product, i.e. the serial carry state.
        sum     = acc_q + addend;
        // Once the N real multiplier bits are shifted out, the register fills with the
        // sign bit (signed) or zeros (unsigned), covering RUN edges N+1..2N.
        mp_fill = signed_q & mp_sign_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    mc_d      = bus.mc;
                    mp_sr_d   = bus.mp;
                    mp_sign_d = bus.mp[N-1];
                    signed_d  = bus.signed_mode;
                    prod_d    = '0;
                    acc_d     = '0;
                    cnt_d     = '0;
                end
            end
            RUN: begin
                // Lowest bit of the partial sum is final: retire it into the top of prod.
                prod_d  = {sum[0], prod_q[2*N-1:1]};
                acc_d   = {sum[AW-1], sum[AW-1:1]};
                mp_sr_d = {mp_fill, mp_sr_q[N-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(2 * N - 1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mc_q      <= '0;
            mp_sr_q   <= '0;
            mp_sign_q <= 1'b0;
            signed_q  <= 1'b0;
            prod_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            mp_sr_q   <= mp_sr_d;
            mp_sign_q <= mp_sign_d;
            signed_q  <= signed_d;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.prod = prod_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_spm_mult_n.sv
// Purpose     : self-checking bench for spm_mult_n at N=8 (directed corners) and N=16 (random).
// Latency     : checks the fixed 2N-cycle schedule and back-to-back restarts.
// Backpressure: n/a.
module tb_spm_mult_n;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    spm_mult_n_if #(.N(8))  if8  ();
    spm_mult_n_if #(.N(16)) if16 ();

    spm_mult_n #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
    spm_mult_n #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    // Reference: plain integer product, operands interpreted per mode, truncated to 2n bits.
    function automatic longint unsigned ref_prod(int n, bit s, longint unsigned a, longint unsigned b);
        longint sa;
        longint sb;
        longint unsigned mask;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[n-1]) sa = sa - (longint'(1) << n);
        if (s && b[n-1]) sb = sb - (longint'(1) << n);
        mask = (longint'(1) << (2 * n)) - 1;
        return longint'(sa * sb) & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue8(bit s, logic [7:0] a, logic [7:0] b);
        if8.start = 1'b1; if8.signed_mode = s; if8.mc = a; if8.mp = b;
        tick();
        if8.start = 1'b0;
    endtask

    task automatic issue16(bit s, logic [15:0] a, logic [15:0] b);
        if16.start = 1'b1; if16.signed_mode = s; if16.mc = a; if16.mp = b;
        tick();
        if16.start = 1'b0;
    endtask

    // Ticks until done is seen; busy must stay high on every cycle before that.
    task automatic wait8(output int cyc, output int busy_cyc);
        cyc = 0; busy_cyc = 0;
        while (!if8.done && cyc < 200) begin
            if (if8.busy) busy_cyc++;
            tick();
            cyc++;
        end
    endtask

    task automatic wait16(output int cyc);
        cyc = 0;
        while (!if16.done && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    // One complete N=8 operation from idle/done with schedule and result checks.
    task automatic op8(string tag, bit s, logic [7:0] a, logic [7:0] b, logic [15:0] exp);
        int cyc;
        int bcyc;
        issue8(s, a, b);
        wait8(cyc, bcyc);
        check({tag, "_latency"}, cyc, 16);
        check({tag, "_busy_cycles"}, bcyc, 16);
        check({tag, "_prod"}, if8.prod, exp);
        check({tag, "_busy_low_in_done"}, if8.busy, 0);
    endtask

    initial begin
        int cyc;
        int bcyc;
        bit s;
        logic [15:0] a;
        logic [15:0] b;

        rst = 1'b1;
        if8.start = 1'b0;  if8.signed_mode = 1'b0;  if8.mc = '0;  if8.mp = '0;
        if16.start = 1'b0; if16.signed_mode = 1'b0; if16.mc = '0; if16.mp = '0;
        repeat (3) tick();
        check("rst_prod",  if8.prod, 0);
        check("rst_busy",  if8.busy, 0);
        check("rst_done",  if8.done, 0);
        check("rst_done16", if16.done, 0);
        rst = 1'b0;
        tick();

        // Directed N=8 corners.
        op8("u5x3",     1'b0, 8'd5,   8'd3,   16'h000F);
        op8("u255x255", 1'b0, 8'hFF,  8'hFF,  16'hFE01);
        op8("s80x80",   1'b1, 8'h80,  8'h80,  16'h4000);
        op8("sFDx07",   1'b1, 8'hFD,  8'h07,  16'hFFEB);
        op8("s7Fx80",   1'b1, 8'h7F,  8'h80,  16'hC080);

        // Result holds in DONE while start stays low.
        repeat (5) tick();
        check("hold_prod", if8.prod, 16'hC080);
        check("hold_done", if8.done, 1);

        // Start re-asserted at RUN edge 5 must be ignored.
        issue8(1'b0, 8'd9, 8'd7);
        check("restart_done_drop", if8.done, 0);
        repeat (4) tick();
        if8.start = 1'b1; if8.signed_mode = 1'b1; if8.mc = 8'd200; if8.mp = 8'd200;
        tick();
        if8.start = 1'b0;
        wait8(cyc, bcyc);
        check("ignore_start_remaining", cyc, 11);
        check("ignore_start_prod", if8.prod, 16'h003F);

        // Reset mid-RUN aborts; the next op must be clean.
        issue8(1'b1, 8'h9C, 8'h4D);
        repeat (8) tick();
        rst = 1'b1;
        #2;
        check("abort_prod_async", if8.prod, 0);
        check("abort_busy_async", if8.busy, 0);
        tick();
        rst = 1'b0;
        issue8(1'b0, 8'd2, 8'd3);
        check("post_rst_busy", if8.busy, 1);
        wait8(cyc, bcyc);
        check("post_rst_latency", cyc, 16);
        check("post_rst_prod", if8.prod, 16'h0006);

        // N=16 random, back-to-back restarts straight out of DONE.
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            if (i == 0) begin a = 16'h8000; b = 16'h8000; s = 1'b1; end
            if (i == 1) begin a = 16'hFFFF; b = 16'hFFFF; s = 1'b0; end
            issue16(s, a, b);
            check("r16_done_drop", if16.done, 0);
            // done low from E0 through E2N-1: one cycle after issue plus the wait minus the last tick.
            wait16(cyc);
            check("r16_done_low_cycles", cyc, 32);
            check("r16_prod", if16.prod, ref_prod(16, s, 64'(a), 64'(b)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
